// File: rtl/shazam_peak_pkg.sv
// Shared types and band lookup for the spectral peak picker.
// Band edges are packed EDGE_W-bit fields, edge 0 in the least significant slot.
package shazam_peak_pkg;

   localparam int unsigned DEF_BIN_W     = 9;
   localparam int unsigned DEF_MAG_W     = 16;
   localparam int unsigned DEF_NUM_BANDS = 4;
   localparam int unsigned EDGE_W        = 16;
   localparam int unsigned MAX_BANDS     = 16;
   localparam int unsigned BAND_IDX_W    = 4;

   localparam logic [(DEF_NUM_BANDS+1)*EDGE_W-1:0] DEF_BAND_EDGES =
      {16'd512, 16'd160, 16'd80, 16'd40, 16'd10};

   typedef struct packed {
      logic [DEF_BIN_W-1:0] bin;
      logic [DEF_MAG_W-1:0] mag;
   } peak_t;

   typedef struct packed {
      logic                  in_range;
      logic [BAND_IDX_W-1:0] band;
   } band_sel_t;

   // Band b covers [edge[b], edge[b+1]); bins outside every band report in_range=0.
   function automatic band_sel_t band_of(
      input logic [EDGE_W-1:0]                 bin,
      input logic [(MAX_BANDS+1)*EDGE_W-1:0]   edges,
      input int unsigned                       num_bands
   );
      band_sel_t sel;
      sel = '0;
      for (int unsigned b = 0; b < MAX_BANDS; b++) begin
         if ((b < num_bands) &&
             (bin >= edges[b*EDGE_W +: EDGE_W]) &&
             (bin <  edges[(b+1)*EDGE_W +: EDGE_W])) begin
            sel.in_range = 1'b1;
            sel.band     = BAND_IDX_W'(b);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/band_max_tracker.sv
// Running maximum of one frequency band within the current frame.
// The merged output already includes the sample being presented this cycle.
module band_max_tracker
   import shazam_peak_pkg::*;
#(
   parameter int unsigned BIN_W = DEF_BIN_W,
   parameter int unsigned MAG_W = DEF_MAG_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clear,
   input  logic                   i_upd,
   input  logic [BIN_W-1:0]       i_bin,
   input  logic [MAG_W-1:0]       i_mag,
   input  logic [MAG_W-1:0]       i_threshold,
   output logic [BIN_W+MAG_W-1:0] o_merged_c,
   output logic                   o_merged_hit_c
);

   logic [BIN_W-1:0] r_bin;
   logic [MAG_W-1:0] r_mag;
   logic             r_hit;
   logic             w_take;

   // Strict greater-than keeps the earliest bin on a tie.
   assign w_take         = i_upd && (i_mag >= i_threshold) && (!r_hit || (i_mag > r_mag));
   assign o_merged_c     = w_take ? {i_bin, i_mag} : {r_bin, r_mag};
   assign o_merged_hit_c = r_hit | w_take;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bin <= '0;
         r_mag <= '0;
         r_hit <= 1'b0;
      end else if (i_clear) begin
         r_bin <= '0;
         r_mag <= '0;
         r_hit <= 1'b0;
      end else if (w_take) begin
         r_bin <= i_bin;
         r_mag <= i_mag;
         r_hit <= 1'b1;
      end
   end

endmodule

// File: rtl/band_peak_picker.sv
// Keeps the strongest bin per band for each FFT frame and publishes a window
// of FRAMES frames as one array with a single-cycle strobe.
module band_peak_picker
   import shazam_peak_pkg::*;
#(
   parameter int unsigned BIN_W     = DEF_BIN_W,
   parameter int unsigned MAG_W     = DEF_MAG_W,
   parameter int unsigned NUM_BANDS = DEF_NUM_BANDS,
   parameter int unsigned FRAMES    = 4,
   parameter logic [(NUM_BANDS+1)*EDGE_W-1:0] BAND_EDGES =
      ((NUM_BANDS+1)*EDGE_W)'(DEF_BAND_EDGES),
   localparam int unsigned ENTRIES  = NUM_BANDS * FRAMES,
   localparam int unsigned PEAK_W   = BIN_W + MAG_W,
   localparam int unsigned FIDX_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           clear,
   input  logic [MAG_W-1:0]               threshold,
   input  logic                           mag_valid,
   input  logic [BIN_W-1:0]               mag_bin,
   input  logic [MAG_W-1:0]               mag_data,
   input  logic                           mag_last,
   output logic [ENTRIES-1:0][PEAK_W-1:0] maximas,
   output logic [ENTRIES-1:0]             band_hit_mask,
   output logic                           maximas_found_active,
   output logic [FIDX_W-1:0]              frame_idx
);

   typedef enum logic {
      S_COLLECT    = 1'b0,
      S_LAST_FRAME = 1'b1
   } state_t;

   localparam state_t            S_START  = (FRAMES == 1) ? S_LAST_FRAME : S_COLLECT;
   localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(FRAMES - 1);

   state_t                           r_state, w_state_nx;
   logic [FIDX_W-1:0]                r_frame_idx, w_frame_idx_nx;
   logic                             w_accept, w_commit, w_publish;
   band_sel_t                        w_sel;
   logic [NUM_BANDS-1:0]             w_upd;
   logic [NUM_BANDS-1:0][PEAK_W-1:0] w_merged;
   logic [NUM_BANDS-1:0]             w_merged_hit;
   logic [ENTRIES-1:0][PEAK_W-1:0]   r_slot, w_slot_nx;
   logic [ENTRIES-1:0]               r_slot_hit, w_slot_hit_nx;
   logic                             r_strobe;

   assign w_accept = mag_valid & enable & ~clear;
   assign w_commit = w_accept & mag_last;
   assign w_sel    = band_of(EDGE_W'(mag_bin), ((MAX_BANDS+1)*EDGE_W)'(BAND_EDGES), NUM_BANDS);

   // Trackers reset on commit so the next frame may start on the following edge.
   for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
      assign w_upd[b] = w_accept & w_sel.in_range & (w_sel.band == BAND_IDX_W'(b));

      band_max_tracker #(
         .BIN_W (BIN_W),
         .MAG_W (MAG_W)
      ) u_trk (
         .i_clk          (clk),
         .i_rst_n        (reset),
         .i_clear        (w_commit | clear),
         .i_upd          (w_upd[b]),
         .i_bin          (mag_bin),
         .i_mag          (mag_data),
         .i_threshold    (threshold),
         .o_merged_c     (w_merged[b]),
         .o_merged_hit_c (w_merged_hit[b])
      );
   end

   // Window contents as they would be after committing the current frame.
   always_comb begin
      w_slot_nx     = r_slot;
      w_slot_hit_nx = r_slot_hit;
      for (int unsigned f = 0; f < FRAMES; f++) begin
         for (int unsigned b = 0; b < NUM_BANDS; b++) begin
            if (r_frame_idx == FIDX_W'(f)) begin
               w_slot_nx[f*NUM_BANDS + b]     = w_merged[b];
               w_slot_hit_nx[f*NUM_BANDS + b] = w_merged_hit[b];
            end
         end
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_frame_idx_nx = r_frame_idx;
      w_publish      = 1'b0;
      if (clear) begin
         w_state_nx     = S_START;
         w_frame_idx_nx = '0;
      end else if (w_commit) begin
         case (r_state)
            S_LAST_FRAME: begin
               w_publish      = 1'b1;
               w_frame_idx_nx = '0;
               w_state_nx     = S_START;
            end
            default: begin
               w_frame_idx_nx = r_frame_idx + 1'b1;
               if (w_frame_idx_nx == LAST_IDX) begin
                  w_state_nx = S_LAST_FRAME;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_START;
         r_frame_idx <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_frame_idx <= w_frame_idx_nx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_slot     <= '0;
         r_slot_hit <= '0;
      end else if (clear) begin
         r_slot     <= '0;
         r_slot_hit <= '0;
      end else if (w_commit) begin
         r_slot     <= w_slot_nx;
         r_slot_hit <= w_slot_hit_nx;
      end
   end

   // Published window is untouched by clear; only a new publish replaces it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         maximas       <= '0;
         band_hit_mask <= '0;
         r_strobe      <= 1'b0;
      end else begin
         r_strobe <= w_publish;
         if (w_publish) begin
            maximas       <= w_slot_nx;
            band_hit_mask <= w_slot_hit_nx;
         end
      end
   end

   assign maximas_found_active = r_strobe;
   assign frame_idx            = r_frame_idx;

endmodule
